inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Small instruction FIFO directly downstream of the IF stage.
- Captures each fetched instruction word from instruction memory, together with the PC that produced it.
- Presents entries in order to the ID stage over a valid/ready handshake.
- Decouples fetch from decode stalls; discards all buffered entries on a taken-branch flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).
- NOP_INST, 32'h00000013, value driven on out_inst when no entry is presented (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  IF presents a fetched instruction this cycle.
- in_pc  input  32  PC of the presented instruction.
- in_inst  input  32  instruction word read from instruction memory.
- in_ready  output  1  queue can accept an entry this cycle.
- flush  input  1  taken branch; discard all entries and any same-cycle push.
- out_valid  output  1  an entry is presented to ID.
- out_pc  output  32  PC of the presented entry.
- out_inst  output  32  instruction of the presented entry.
- out_ready  input  1  ID consumes the presented entry this cycle.
- count  output  PTR_W+1  number of stored entries (0..DEPTH).
- misaligned  output  1  sticky flag: an accepted in_pc had bits [1:0] != 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. It takes effect immediately, not at the next clock edge.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, misaligned=0, out_valid=0, out_pc=0, out_inst=NOP_INST. Storage contents are not reset.
- in_ready = (count != DEPTH). It is purely a function of registered state, with no combinational path from out_ready or flush.
- push = in_valid & in_ready & ~flush: write {in_pc,in_inst} to mem[wr_ptr]; wr_ptr++ (wraps modulo DEPTH).
- pop = out_valid & out_ready & ~flush: rd_ptr++ (wraps modulo DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on push&pop.
- Full (count==DEPTH): in_ready=0, so no push, even if a pop occurs in the same cycle. in_ready rises on the cycle after the pop.
- Empty (count==0): out_valid=0, out_pc=0, out_inst=NOP_INST. out_ready is ignored.
- Non-empty: out_valid=1, out_pc/out_inst = mem[rd_ptr], combinational from storage.
- Latency: a pushed entry is visible on out_* the cycle after the push edge (1 cycle minimum).
- flush (synchronous, highest priority):
  - Next edge: wr_ptr=0, rd_ptr=0, count=0.
  - A same-cycle push and pop are both suppressed; out_valid is 0 the following cycle.
  - misaligned is not cleared by flush.
- misaligned: set on any push with in_pc[1:0]!=0. Cleared only by reset. The entry is still stored and delivered unchanged.
- Pointer arithmetic is PTR_W bits with natural wrap. count is PTR_W+1 bits and never exceeds DEPTH.
- Reset asserted mid-operation: all entries are lost and outputs return to reset values asynchronously.

Optional Feature:
- Macro: INST_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and in_valid & ~flush, out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally.
  - If out_ready is also 1 that cycle, the entry is consumed directly: no write, pointers and count unchanged.
  - If out_ready is 0, a normal push occurs.
  - Zero-cycle latency when empty.
- Undefined: no bypass; out_* depends only on storage, with the 1-cycle minimum latency described above.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then in_valid=0 -> out_valid=0, out_inst=32'h00000013, count=0, in_ready=1.
- In-order fill/drain: push PCs 0,4,8,C with insts 32'h11111111..32'h44444444 while out_ready=0 -> count=4, in_ready=0. Then out_ready=1 -> pops in order 0,4,8,C, count returns to 0.
- Full with simultaneous pop: count=4, in_valid=1 (PC 10), out_ready=1 -> pop of PC 0 only, PC 10 not accepted, count=3. Next cycle PC 10 is accepted.
- Flush: 3 entries queued, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. A subsequent push of PC 40 appears on out_pc one cycle later.
- Wrap-around: sustain 10 push/pop pairs with PCs 0..24 step 4 and out_ready=1 -> outputs in exact order, count stays at 1, no loss or duplication.
- Misaligned and bypass: push in_pc=32'h00000006 -> misaligned=1, stays 1 through a flush. With INST_FETCH_QUEUE_BYPASS_EN defined, empty queue, in_valid=1 and out_ready=1 -> out_valid=1 in the same cycle, count stays 0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : IF->ID instruction FIFO carrying {pc, inst}, flushable on taken
//            branch. Optional empty-queue bypass: INST_FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             misaligned
);

  localparam logic [PTR_W:0]   c_full    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  logic [31:0]      r_mem_pc   [DEPTH];
  logic [31:0]      r_mem_inst [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_misaligned;

  logic w_stored_valid;
  logic w_push;
  logic w_pop;
  logic w_accept;

  assign w_stored_valid = (r_count != '0);
  assign in_ready       = (r_count != c_full);
  assign count          = r_count;
  assign misaligned     = r_misaligned;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  logic w_bypass_take;

  // Empty queue forwards the fetched word straight through to ID.
  assign w_bypass      = !w_stored_valid && in_valid && !flush;
  assign w_bypass_take = w_bypass && out_ready;
  assign w_push        = in_valid && in_ready && !flush && !w_bypass_take;
  assign w_pop         = w_stored_valid && out_ready && !flush;
  assign w_accept      = w_push || w_bypass_take;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = NOP_INST;
    if (w_stored_valid) begin
      out_valid = 1'b1;
      out_pc    = r_mem_pc[r_rd_ptr];
      out_inst  = r_mem_inst[r_rd_ptr];
    end else if (w_bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
  end
`else
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = w_stored_valid && out_ready && !flush;
  assign w_accept = w_push;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = NOP_INST;
    if (w_stored_valid) begin
      out_valid = 1'b1;
      out_pc    = r_mem_pc[r_rd_ptr];
      out_inst  = r_mem_inst[r_rd_ptr];
    end
  end
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= in_pc;
      r_mem_inst[r_wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_accept && (in_pc[1:0] != 2'b00)) begin
        r_misaligned <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
